mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle processor FSM.
// Services MemRead/MemWrite after WAIT_CYCLES wait states and signals
// completion with a one-cycle ready pulse. It holds the word-addressed data
// array and has a loader port for preloading the array while the processor
// is idle.
// Optional access statistics (rd_count/wr_count) are built when the macro
// MEM_STATS_EN is defined.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              proto_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_reject
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The wait counter counts down from WAIT_CYCLES-1 to 0 while in WAIT.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              proto_err_q;
  logic              ld_reject_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              is_idle;
  logic              rd_req;
  logic              wr_req;
  logic              both_req;
  logic              start;
  logic              commit;
  logic              c_op_wr;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              commit_rd;
  logic              commit_wr;
  logic              ld_ok;
  logic              ld_rej_d;

  assign is_idle  = (state_q == S_IDLE);
  assign rd_req   = MemRead & ~MemWrite;
  assign wr_req   = MemWrite & ~MemRead;
  assign both_req = MemRead & MemWrite;
  assign start    = is_idle & (rd_req | wr_req);

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (NO_WAIT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The commit happens on the edge that enters DONE. With no wait states that
  // edge is the one leaving IDLE, so the live request fields are used directly;
  // otherwise the copies latched on entry to WAIT are used.
  assign commit    = ((state_q == S_WAIT) && (cnt_q == 4'd0)) || (start && NO_WAIT);
  assign c_op_wr   = is_idle ? wr_req : op_wr_q;
  assign c_addr    = is_idle ? addr   : addr_q;
  assign c_wdata   = is_idle ? wdata  : wdata_q;

  // Reset aborts an in-flight access, so a commit coinciding with reset is dropped.
  assign commit_rd = commit & ~c_op_wr & ~reset;
  assign commit_wr = commit &  c_op_wr & ~reset;

  // The loader only gets the array when the processor is idle and not asking.
  assign ld_ok    = ld_we & is_idle & ~MemRead & ~MemWrite;
  assign ld_rej_d = ld_we & ~ld_ok;

  // Control state: FSM, counter, latched op and the one-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      proto_err_q <= 1'b0;
      ld_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      proto_err_q <= is_idle & both_req;
      ld_reject_q <= ld_rej_d;
      if (start) begin
        op_wr_q <= wr_req;
      end
    end
  end

  // Request address and write data captured when an access is accepted.
  always_ff @(posedge clock) begin
    if (start) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Read data register: only a READ commit changes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (commit_rd) begin
      rdata_q <= mem_q[c_addr];
    end
  end

  // Array write port shared by processor commits and the loader; the two
  // can never fire in the same cycle because the loader needs both strobes low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (commit_wr) begin
        mem_q[c_addr] <= c_wdata;
      end else if (ld_ok) begin
        mem_q[ld_addr] <= ld_data;
      end
    end
  end

`ifdef MEM_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Commit counters, saturating at all-ones; loader writes are not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      if (commit_rd) begin
        rd_count_q <= sat_inc16(rd_count_q);
      end
      if (commit_wr) begin
        wr_count_q <= sat_inc16(wr_count_q);
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  assign rdata     = rdata_q;
  assign ready     = (state_q == S_DONE);
  assign busy      = ~is_idle;
  assign proto_err = proto_err_q;
  assign ld_reject = ld_reject_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed steps plus a randomized phase checked
// against an array model. A second instance runs with no wait states.
module tb_mem_responder;

  localparam int WC = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       MemRead = 1'b0, MemWrite = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic [7:0] rdata;
  logic       ready, busy, proto_err;
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = '0, ld_data = '0;
  logic       ld_reject;

  logic       MemRead0 = 1'b0, MemWrite0 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0;
  logic [7:0] rdata0;
  logic       ready0, busy0, proto_err0;
  logic       ld_we0 = 1'b0;
  logic [7:0] ld_addr0 = '0, ld_data0 = '0;
  logic       ld_reject0;

`ifdef MEM_STATS_EN
  logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WC)) dut (
    .clock(clock), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .proto_err(proto_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_reject(ld_reject)
`ifdef MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .MemRead(MemRead0), .MemWrite(MemWrite0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .proto_err(proto_err0),
    .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0), .ld_reject(ld_reject0)
`ifdef MEM_STATS_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: array contents and the expected rdata register.
  logic [7:0] mdl_mem  [256];
  logic [7:0] exp_rdata  = 8'h00;
  logic [7:0] exp_rdata0 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input bit sel, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (sel) begin
      MemRead0 = ~wr; MemWrite0 = wr; addr0 = a; wdata0 = d;
    end else begin
      MemRead = ~wr; MemWrite = wr; addr = a; wdata = d;
    end
  endtask

  // Waits for ready (bounded), checking busy on the way; n0 = edges already
  // elapsed since the request was driven. Drops strobes, then checks idle.
  task automatic wait_ready(input bit sel, input int n0, output int lat);
    int  n;
    bit  seen;
    logic r, b;
    n = n0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      r = sel ? ready0 : ready;
      b = sel ? busy0 : busy;
      chk("busy_during_access", b, 1);
      if (r) seen = 1'b1;
    end
    MemRead = 0; MemWrite = 0; MemRead0 = 0; MemWrite0 = 0;
    lat = seen ? n : -1;
    tick();
    chk("ready_pulse_one_cycle", sel ? ready0 : ready, 0);
    chk("busy_back_idle", sel ? busy0 : busy, 0);
  endtask

  task automatic access(input bit sel, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int lat;
    start_req(sel, wr, a, d);
    wait_ready(sel, 0, lat);
    chk(sel ? "latency_wc0" : "latency", lat, sel ? 1 : WC + 1);
    if (wr) begin
      mdl_mem[a] = d;
    end else if (sel) begin
      exp_rdata0 = mdl_mem[a];
    end else begin
      exp_rdata = mdl_mem[a];
    end
    chk(sel ? "rdata_wc0" : "rdata", sel ? rdata0 : rdata, sel ? exp_rdata0 : exp_rdata);
  endtask

  task automatic load(input bit sel, input logic [7:0] a, input logic [7:0] d);
    if (sel) begin
      ld_we0 = 1; ld_addr0 = a; ld_data0 = d;
    end else begin
      ld_we = 1; ld_addr = a; ld_data = d;
    end
    tick();
    ld_we = 0; ld_we0 = 0;
    chk("ld_accept", sel ? ld_reject0 : ld_reject, 0);
    mdl_mem[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] pool [8];

    // Reset and reset-state checks.
    reset = 1;
    tick(); tick();
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_ld_reject", ld_reject, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_busy0", busy0, 0);
    reset = 0;
    tick();
    chk("idle_ready", ready, 0);

    // Loader preload, then read it back with wait states.
    load(0, 8'h10, 8'hA5);
    access(0, 0, 8'h10, 8'h00);
    chk("read_preloaded", rdata, 8'hA5);

    // Write then read; rdata must not move across the write.
    access(0, 1, 8'h20, 8'h3C);
    chk("rdata_hold_over_write", rdata, 8'hA5);
    access(0, 0, 8'h20, 8'h00);
    chk("raw_same_addr", rdata, 8'h3C);

    // Both strobes together: protocol error, no access.
    MemRead = 1; MemWrite = 1; addr = 8'h20; wdata = 8'hFF;
    tick();
    MemRead = 0; MemWrite = 0;
    chk("proto_err_pulse", proto_err, 1);
    chk("proto_busy", busy, 0);
    chk("proto_ready", ready, 0);
    tick();
    chk("proto_err_clear", proto_err, 0);
    chk("proto_ready2", ready, 0);
    chk("proto_rdata_kept", rdata, 8'h3C);
    access(0, 0, 8'h20, 8'h00);
    chk("proto_array_kept", rdata, 8'h3C);

    // Loader write during WAIT is refused.
    start_req(0, 0, 8'h10, 8'h00);
    tick();
    chk("in_wait_busy", busy, 1);
    ld_we = 1; ld_addr = 8'h10; ld_data = 8'h77;
    tick();
    ld_we = 0;
    chk("ld_reject_wait", ld_reject, 1);
    wait_ready(0, 2, lat);
    chk("latency_ldrej", lat, WC + 1);
    chk("ldrej_rdata", rdata, 8'hA5);
    chk("ld_reject_clear", ld_reject, 0);

    // Loader write in IDLE colliding with a processor read is refused.
    start_req(0, 0, 8'h10, 8'h00);
    ld_we = 1; ld_addr = 8'h10; ld_data = 8'h77;
    tick();
    ld_we = 0;
    chk("ld_reject_strobe", ld_reject, 1);
    wait_ready(0, 1, lat);
    chk("latency_ldcollide", lat, WC + 1);
    chk("ldcollide_rdata", rdata, 8'hA5);

    // Reset in the last WAIT cycle of a write aborts it.
    load(0, 8'h30, 8'h11);
    start_req(0, 1, 8'h30, 8'hEE);
    tick();
    tick();
    chk("pre_reset_busy", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    MemWrite = 0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    chk("abort_rdata_reset", rdata, 0);
    exp_rdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_ready", ready, 0);
    end
    access(0, 0, 8'h30, 8'h00);
    chk("abort_write_dropped", rdata, 8'h11);

    // Randomized mix of loader writes, processor writes and reads.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 8'($urandom_range(0, 255));
      load(0, pool[i], 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [7:0] a, d;
      k = $urandom_range(0, 2);
      a = pool[$urandom_range(0, 7)];
      d = 8'($urandom_range(0, 255));
      if (k == 0) begin
        load(0, a, d);
      end else if (k == 1) begin
        access(0, 1, a, d);
      end else begin
        access(0, 0, a, d);
      end
    end

    // Zero wait-state instance: 3 reads and 2 writes.
    load(1, 8'h05, 8'h5A);
    access(1, 1, 8'h06, 8'hC3);
    access(1, 0, 8'h05, 8'h00);
    chk("wc0_read1", rdata0, 8'h5A);
    access(1, 0, 8'h06, 8'h00);
    chk("wc0_read2", rdata0, 8'hC3);
    access(1, 1, 8'h05, 8'h99);
    access(1, 0, 8'h05, 8'h00);
    chk("wc0_read3", rdata0, 8'h99);
`ifdef MEM_STATS_EN
    chk("rd_count", rd_count0, 3);
    chk("wr_count", wr_count0, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
